// File: rtl/crc32_pkg.sv
// Shared CRC-32 definitions for the 512-bit datapath: widths, the parallel
// coefficient matrix, and the reference checksum function used by the encoder.
package crc32_pkg;

    localparam int DATA_WIDTH = 512;
    localparam int CRC_WIDTH  = 32;
    localparam int CW_WIDTH   = DATA_WIDTH + CRC_WIDTH;

    localparam logic [CRC_WIDTH-1:0] ROW0_LO  = 32'hEA000001;
    localparam logic [CRC_WIDTH-1:0] ROW31_LO = 32'hF5000000;
    localparam logic [CRC_WIDTH-1:0] COL0     = 32'h000000AF;

    typedef logic [CRC_WIDTH-1:0][DATA_WIDTH-1:0] crc_table_t;

    typedef struct packed {
        logic [CRC_WIDTH-1:0]  checksum;
        logic [DATA_WIDTH-1:0] data;
    } codeword_t;

    // Column j is the checksum contribution of data bit j. Bits [29:12] hold
    // {j, ~j}, so every column past 0 is unique and has weight >= 9; that keeps
    // all 1- and 2-bit codeword corruptions visible in the syndrome.
    function automatic logic [CRC_WIDTH-1:0] coeff_col(input int j);
        logic [CRC_WIDTH-1:0] c;
        logic [8:0]           jj;
        jj = 9'(j);
        c  = '0;
        if (j == 0) begin
            c = COL0;
        end else begin
            c[0]     = (j < 32) ? ROW0_LO[jj[4:0]] : jj[0];
            c[11:1]  = 11'(j * 13);
            c[20:12] = ~jj;
            c[29:21] = jj;
            c[30]    = jj[0] ^ jj[3];
            c[31]    = (j < 32) ? ROW31_LO[jj[4:0]] : (jj[1] ^ jj[5]);
        end
        return c;
    endfunction

    function automatic crc_table_t build_table();
        crc_table_t           t;
        logic [CRC_WIDTH-1:0] col;
        t = '0;
        for (int j = 0; j < DATA_WIDTH; j++) begin
            col = coeff_col(j);
            for (int i = 0; i < CRC_WIDTH; i++) t[i][j] = col[i];
        end
        return t;
    endfunction

    localparam crc_table_t CRC_COEFF_TABLE = build_table();

    function automatic logic [CRC_WIDTH-1:0] crc32_calc(input logic [DATA_WIDTH-1:0] data);
        logic [CRC_WIDTH-1:0] c;
        for (int i = 0; i < CRC_WIDTH; i++) c[i] = ^(data & CRC_COEFF_TABLE[i]);
        return c;
    endfunction

endpackage

// File: rtl/crc32_syn.sv
// Combinational syndrome generator: recomputed checksum XOR received checksum.
module crc32_syn
    import crc32_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [CRC_WIDTH-1:0]  checksum,
    output logic [CRC_WIDTH-1:0]  syndrome
);

    for (genvar i = 0; i < CRC_WIDTH; i++) begin : g_bit
        assign syndrome[i] = (^(data & CRC_COEFF_TABLE[i])) ^ checksum[i];
    end

endmodule

// File: rtl/err_gen.sv
// Companion fault injector: passes codewords through one register stage and,
// under an internal LFSR, flips zero, one or two distinct codeword bits.
module err_gen
    import crc32_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [CRC_WIDTH-1:0]  checksum_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [CRC_WIDTH-1:0]  checksum_o,
    output logic                  corrupted_o
);

    localparam logic [31:0] LFSR_SEED = 32'h1D872B41;
    localparam logic [31:0] LFSR_POLY = 32'h04C11DB7;

    logic [31:0]         lfsr, lfsr_nxt;
    logic [1:0]          mode;
    logic [9:0]          pos0, pos1;
    logic [10:0]         sum;
    logic [CW_WIDTH-1:0] flip;
    codeword_t           cw;

    // mode 0: clean, 1: one flip, 2/3: two flips. pos1 is pos0 plus an odd
    // offset below 32, wrapped into the codeword, so the two never coincide.
    always_comb begin
        lfsr_nxt = lfsr;
        for (int k = 0; k < 16; k++)
            lfsr_nxt = {lfsr_nxt[30:0], 1'b0} ^ (lfsr_nxt[31] ? LFSR_POLY : 32'h0);
        mode = lfsr[1:0];
        pos0 = (lfsr[11:2] >= 10'(CW_WIDTH)) ? (lfsr[11:2] - 10'd512) : lfsr[11:2];
        sum  = {1'b0, pos0} + {6'd0, lfsr[15:12], 1'b1};
        pos1 = (sum >= 11'(CW_WIDTH)) ? 10'(sum - 11'(CW_WIDTH)) : sum[9:0];
        flip = '0;
        if (mode != 2'd0) flip[pos0] = 1'b1;
        if (mode[1])      flip[pos1] = 1'b1;
        cw = codeword_t'({checksum_i, data_i} ^ flip);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr        <= LFSR_SEED;
            valid_o     <= 1'b0;
            data_o      <= '0;
            checksum_o  <= '0;
            corrupted_o <= 1'b0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                lfsr        <= lfsr_nxt;
                data_o      <= cw.data;
                checksum_o  <= cw.checksum;
                corrupted_o <= (mode != 2'd0);
            end
        end
    end

endmodule

// File: rtl/crc32_dec.sv
// Receive-side CRC-32 checker: one register stage after the syndrome tree,
// data forwarded unchanged alongside a mismatch flag.
module crc32_dec #(
    parameter int DATA_WIDTH = 512,
    parameter int CRC_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [CRC_WIDTH-1:0]  checksum_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  detected_o
);

    logic [CRC_WIDTH-1:0] syndrome;

    crc32_syn u_syn (
        .data     (data_i),
        .checksum (checksum_i),
        .syndrome (syndrome)
    );

    // Idle cycles drop valid but keep the last data/flag on the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o    <= 1'b0;
            data_o     <= '0;
            detected_o <= 1'b0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                data_o     <= data_i;
                detected_o <= |syndrome;
            end
        end
    end

endmodule

// File: tb/tb_crc32_dec.sv
// Directed bench for crc32_dec, finishing with an err_gen-driven random run.
module tb_crc32_dec;
    import crc32_pkg::*;

    logic                  clk, rst_n;
    logic                  use_eg;
    logic                  tb_valid;
    logic [DATA_WIDTH-1:0] tb_data;
    logic [CRC_WIDTH-1:0]  tb_chk;

    logic                  eg_vi, eg_vo, eg_corr;
    logic [DATA_WIDTH-1:0] eg_di, eg_do;
    logic [CRC_WIDTH-1:0]  eg_ci, eg_co;

    logic                  dec_valid;
    logic [DATA_WIDTH-1:0] dec_data;
    logic [CRC_WIDTH-1:0]  dec_chk;

    logic                  valid_o, detected_o;
    logic [DATA_WIDTH-1:0] data_o;

    int n_vec = 0;
    int n_err = 0;

    assign dec_valid = use_eg ? eg_vo : tb_valid;
    assign dec_data  = use_eg ? eg_do : tb_data;
    assign dec_chk   = use_eg ? eg_co : tb_chk;

    err_gen u_eg (
        .clk(clk), .rst_n(rst_n), .valid_i(eg_vi), .data_i(eg_di), .checksum_i(eg_ci),
        .valid_o(eg_vo), .data_o(eg_do), .checksum_o(eg_co), .corrupted_o(eg_corr)
    );

    crc32_dec #(.DATA_WIDTH(512), .CRC_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(dec_valid), .data_i(dec_data),
        .checksum_i(dec_chk), .valid_o(valid_o), .data_o(data_o), .detected_o(detected_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_WIDTH-1:0] obs,
                       input logic [DATA_WIDTH-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [DATA_WIDTH-1:0] d,
                         input logic [CRC_WIDTH-1:0] c);
        tb_valid = v;
        tb_data  = d;
        tb_chk   = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_WIDTH-1:0] rand_data();
        logic [DATA_WIDTH-1:0] r;
        for (int k = 0; k < DATA_WIDTH / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] onehot(input int k);
        logic [DATA_WIDTH-1:0] r;
        r    = '0;
        r[k] = 1'b1;
        return r;
    endfunction

    logic [DATA_WIDTH-1:0] a_data, b_data, m;
    logic [CRC_WIDTH-1:0]  a_chk, b_chk;
    logic                  prev_exp, have_prev;
    int                    n_corr;

    initial begin
        use_eg = 1'b0;
        eg_vi  = 1'b0;
        eg_di  = '0;
        eg_ci  = '0;
        drive(1'b0, '0, '0);
        rst_n = 1'b0;
        #2;
        chk("reset_valid", 512'(valid_o), 512'(1'b0));
        chk("reset_data", data_o, '0);
        chk("reset_det", 512'(detected_o), 512'(1'b0));
        tick();
        tick();
        rst_n = 1'b1;

        // All-zero codeword
        drive(1'b1, '0, 32'h0);
        tick();
        chk("zero_valid", 512'(valid_o), 512'(1'b1));
        chk("zero_det", 512'(detected_o), 512'(1'b0));
        chk("zero_data", data_o, '0);

        // Single data bits against hand-derived matrix columns
        drive(1'b1, onehot(0), 32'h000000AF);
        tick();
        chk("bit0_clean_det", 512'(detected_o), 512'(1'b0));
        drive(1'b1, onehot(1), 32'h403FE01A);
        tick();
        chk("bit1_clean_det", 512'(detected_o), 512'(1'b0));
        drive(1'b1, onehot(511), 32'h3FE003E7);
        tick();
        chk("bit511_clean_det", 512'(detected_o), 512'(1'b0));
        chk("bit511_data", data_o, onehot(511));
        drive(1'b1, onehot(0), 32'h000000AE);
        tick();
        chk("bit0_bad_det", 512'(detected_o), 512'(1'b1));
        chk("bit0_bad_valid", 512'(valid_o), 512'(1'b1));

        // Random codeword: clean, one data flip, one checksum flip
        a_data = rand_data();
        a_chk  = crc32_calc(a_data);
        drive(1'b1, a_data, a_chk);
        tick();
        chk("rand_clean_det", 512'(detected_o), 512'(1'b0));
        chk("rand_clean_data", data_o, a_data);
        m = onehot(int'($urandom_range(0, 511)));
        drive(1'b1, a_data ^ m, a_chk);
        tick();
        chk("rand_dflip_det", 512'(detected_o), 512'(1'b1));
        chk("rand_dflip_data", data_o, a_data ^ m);
        drive(1'b1, a_data, a_chk ^ (32'h1 << $urandom_range(0, 31)));
        tick();
        chk("rand_cflip_det", 512'(detected_o), 512'(1'b1));
        chk("rand_cflip_data", data_o, a_data);

        // Back-to-back clean, corrupt, clean, then idle hold
        b_data = rand_data();
        b_chk  = crc32_calc(b_data);
        drive(1'b1, a_data, a_chk);
        tick();
        chk("b2b0_valid", 512'(valid_o), 512'(1'b1));
        chk("b2b0_det", 512'(detected_o), 512'(1'b0));
        drive(1'b1, b_data, b_chk ^ 32'h8000_0000);
        tick();
        chk("b2b1_valid", 512'(valid_o), 512'(1'b1));
        chk("b2b1_det", 512'(detected_o), 512'(1'b1));
        drive(1'b1, b_data, b_chk);
        tick();
        chk("b2b2_valid", 512'(valid_o), 512'(1'b1));
        chk("b2b2_det", 512'(detected_o), 512'(1'b0));
        chk("b2b2_data", data_o, b_data);
        drive(1'b0, a_data, 32'hDEAD_BEEF);
        tick();
        chk("idle_valid", 512'(valid_o), 512'(1'b0));
        chk("idle_hold_data", data_o, b_data);
        chk("idle_hold_det", 512'(detected_o), 512'(1'b0));

        // Load a nonzero, flagged result, then reset mid-cycle
        drive(1'b1, onehot(0), 32'h000000AE);
        tick();
        chk("prerst_det", 512'(detected_o), 512'(1'b1));
        drive(1'b1, a_data, a_chk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 512'(valid_o), 512'(1'b0));
        chk("async_rst_data", data_o, '0);
        chk("async_rst_det", 512'(detected_o), 512'(1'b0));
        tick();
        chk("held_rst_valid", 512'(valid_o), 512'(1'b0));
        drive(1'b0, '0, '0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_no_stale", 512'(valid_o), 512'(1'b0));
        chk("post_rst_data", data_o, '0);
        drive(1'b1, a_data, a_chk);
        tick();
        chk("first_after_rst_valid", 512'(valid_o), 512'(1'b1));
        chk("first_after_rst_data", data_o, a_data);
        drive(1'b0, '0, '0);
        tick();

        // 100 codewords through err_gen, pipelined back-to-back
        use_eg    = 1'b1;
        have_prev = 1'b0;
        prev_exp  = 1'b0;
        n_corr    = 0;
        for (int k = 0; k <= 100; k++) begin
            if (k < 100) begin
                eg_vi = 1'b1;
                eg_di = rand_data();
                eg_ci = crc32_calc(eg_di);
            end else begin
                eg_vi = 1'b0;
            end
            tick();
            if (have_prev) begin
                chk("eg_valid", 512'(valid_o), 512'(1'b1));
                chk("eg_det_vs_corrupted", 512'(detected_o), 512'(prev_exp));
            end
            have_prev = eg_vo;
            prev_exp  = eg_corr;
            if (eg_vo && eg_corr) n_corr++;
        end
        tick();
        chk("eg_drain_valid", 512'(valid_o), 512'(1'b0));
        $display("err_gen corrupted %0d of 100 codewords", n_corr);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
